cdb_arbiter: RTL

Arbiter for the four common-data-bus forward ports (forwardA..forwardD) consumed by every reservation station and the ROB. It collects completed results from NUM_REQ functional-unit requesters and grants up to four per cycle with rotating priority. Granted results are registered onto the forward buses with one-cycle latency. All grants are dropped on pipeline flush.

---
 rtl/cdb_arbiter_if.sv | 33 +++
 rtl/cdb_arbiter.sv | 81 ++++++++
 2 files changed

// File: rtl/cdb_arbiter_if.sv
// Result-requester handshake and the four registered common-data-bus forward ports.
// master = functional-unit/consumer side, slave = the arbiter.
interface cdb_arbiter_if #(
  parameter int NUM_REQ = 6
);
  logic [NUM_REQ-1:0]    req_valid;
  logic [22*NUM_REQ-1:0] req_data;
  logic [NUM_REQ-1:0]    req_ready;
  logic [22:0]           forwardA;
  logic [22:0]           forwardB;
  logic [22:0]           forwardC;
  logic [22:0]           forwardD;

  modport master (
    output req_valid,
    output req_data,
    input  req_ready,
    input  forwardA,
    input  forwardB,
    input  forwardC,
    input  forwardD
  );

  modport slave (
    input  req_valid,
    input  req_data,
    output req_ready,
    output forwardA,
    output forwardB,
    output forwardC,
    output forwardD
  );
endinterface

// File: rtl/cdb_arbiter.sv
// CDB arbiter: grants up to four completed results per cycle with rotating priority; forward buses registered (1 cycle).
// req_ready is combinational from req_valid, forced low on flush/reset; requesters hold until granted.
module cdb_arbiter #(
  parameter int NUM_REQ = 6
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         flush,
  cdb_arbiter_if.slave cdb
);

  localparam int NUM_BUS = 4;
  localparam int PTR_W   = $clog2(NUM_REQ);
  localparam int SLICE_W = 22;
  localparam logic [PTR_W:0] N_EXT = (PTR_W+1)'(NUM_REQ);

  typedef struct packed {
    logic        vld;
    logic [5:0]  tag;
    logic [15:0] val;
  } fwd_t;

  logic [PTR_W-1:0]         rr_ptr_q;
  logic [PTR_W-1:0]         rr_ptr_d;
  fwd_t [NUM_BUS-1:0]       fwd_q;
  fwd_t [NUM_BUS-1:0]       fwd_d;
  logic [NUM_REQ-1:0]       grant;

  // Operand is always below 2*NUM_REQ, so one conditional subtract is a full modulo.
  function automatic logic [PTR_W-1:0] wrap_idx(input logic [PTR_W:0] v);
    logic [PTR_W:0] r;
    r = (v >= N_EXT) ? (v - N_EXT) : v;
    return r[PTR_W-1:0];
  endfunction

  always_comb begin : grant_sel
    logic [2:0]       n_grant;
    logic [PTR_W-1:0] idx;
    logic [PTR_W-1:0] last_idx;
    grant    = '0;
    fwd_d    = '0;
    n_grant  = '0;
    idx      = '0;
    last_idx = rr_ptr_q;
    rr_ptr_d = rr_ptr_q;
    for (int k = 0; k < NUM_REQ; k++) begin
      idx = wrap_idx({1'b0, rr_ptr_q} + (PTR_W+1)'(k));
      // n-th grant in scan order drives bus n (A, B, C, D)
      if (!reset && !flush && cdb.req_valid[idx] && (n_grant < 3'(NUM_BUS))) begin
        grant[idx]          = 1'b1;
        fwd_d[n_grant[1:0]] = {1'b1, cdb.req_data[SLICE_W*idx +: SLICE_W]};
        n_grant             = n_grant + 3'd1;
        last_idx            = idx;
      end
    end
    if (n_grant != 3'd0) begin
      rr_ptr_d = wrap_idx({1'b0, last_idx} + (PTR_W+1)'(1));
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rr_ptr_q <= '0;
      fwd_q    <= '0;
    end else begin
      rr_ptr_q <= rr_ptr_d;
      fwd_q    <= fwd_d;
    end
  end

  assign cdb.req_ready = grant;
  assign cdb.forwardA  = fwd_q[0];
  assign cdb.forwardB  = fwd_q[1];
  assign cdb.forwardC  = fwd_q[2];
  assign cdb.forwardD  = fwd_q[3];

  // Grants never exceed the bus count and only go to requesters holding a result.
  a_max_grants: assert property (@(posedge clk) $countones(grant) <= NUM_BUS);
  a_grant_valid: assert property (@(posedge clk) (grant & ~cdb.req_valid) == '0);

endmodule
